// File: rtl/uart_rx_deser.sv
// UART 8N1 receiver: 2-flop input sync, mid-bit sampling, valid/ready byte output.
// Stop bit sampled 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT cycles after start edge; byte 1 cycle later.
module uart_rx_deser #(
  parameter int CLKS_PER_BIT = 8,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BRK} state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 sync1, rx_s;
  logic                 deliver;
  logic                 cnt_clr, shift_en, stop_ok, stop_bad;
  logic                 at_half, at_last;

  assign at_half = (cnt == CW'(CLKS_PER_BIT/2 - 1));
  assign at_last = (cnt == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_n  = state;
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (state)
      S_IDLE:  if (!rx_s) state_n = S_START;
      S_START: if (at_half) state_n = rx_s ? S_IDLE : S_DATA;
      S_DATA: begin
        if (at_last) begin
          shift_en = 1'b1;
          cnt_clr  = 1'b1;
          if (bit_idx == IW'(DATA_BITS-1)) state_n = S_STOP;
        end
      end
      S_STOP: begin
        // Leaving at the stop-bit midpoint lets a gapless next start bit be seen.
        if (at_last) begin
          if (rx_s) begin
            stop_ok = 1'b1;
            state_n = S_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_n  = S_BRK;
          end
        end
      end
      S_BRK:   if (rx_s) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b1;
      rx_s      <= 1'b1;
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      deliver   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
      state <= state_n;
      if (state_n != state || cnt_clr || state == S_IDLE || state == S_BRK)
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);
      if (state != S_DATA)
        bit_idx <= '0;
      else if (shift_en)
        bit_idx <= bit_idx + IW'(1);
      if (shift_en)
        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      deliver   <= stop_ok;
      frame_err <= stop_bad;
      // A held byte is never overwritten; the newcomer is dropped and flagged.
      overrun   <= deliver & rx_valid & ~rx_ready;
      if (deliver && (!rx_valid || rx_ready)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
